voice_scheduler: RTL

//  Owns the polyphony slot table that sequences the pipelined phase bank. Accepts MIDI-style commands over valid/ready.

---
 rtl/voice_scheduler_pkg.sv | 68 ++++++
 rtl/voice_scheduler_if.sv | 18 +
 rtl/voice_dispatch_rr.sv | 70 +++++++
 rtl/voice_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler_pkg
// Description : Shared constants, enums and the command decoder for the
//               voice scheduler. It holds the waveform codes, the i_data field
//               positions and the CHANGE_WAVE / STOP_ALL encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package voice_scheduler_pkg;

  localparam int unsigned C_DATA_W    = 16;
  localparam int unsigned C_ONOFF_BIT = 15;
  localparam int unsigned C_MIDI_MSB  = 14;
  localparam int unsigned C_MIDI_LSB  = 8;
  localparam int unsigned C_VEL_MSB   = 7;
  localparam int unsigned C_VEL_LSB   = 0;

  // A slot whose note is zero is free.
  localparam logic [6:0] C_MIDI_NONE     = 7'h00;
  // Note-off of this note clears the whole table.
  localparam logic [6:0] C_MIDI_STOP_ALL = 7'h7F;
  localparam logic [7:0] C_VEL_NONE      = 8'h00;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_SAWTOOTH = 2'd2,
    WAVE_TRIANGLE = 2'd3
  } wave_e;

  typedef enum logic [2:0] {
    CMD_NOTE_ON     = 3'd0,
    CMD_NOTE_OFF    = 3'd1,
    CMD_CHANGE_WAVE = 3'd2,
    CMD_STOP_ALL    = 3'd3,
    CMD_BAD_ON      = 3'd4,
    CMD_IGNORE      = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Classify a raw command word. Note zero is reserved for control codes.
  function automatic cmd_e decode_cmd(input logic [C_DATA_W-1:0] data);
    logic       on;
    logic [6:0] midi;
    logic [7:0] vel;
    cmd_e       cmd;
    on   = data[C_ONOFF_BIT];
    midi = data[C_MIDI_MSB:C_MIDI_LSB];
    vel  = data[C_VEL_MSB:C_VEL_LSB];
    if (on) begin
      if (midi != C_MIDI_NONE)     cmd = CMD_NOTE_ON;
      else if (vel == C_VEL_NONE)  cmd = CMD_CHANGE_WAVE;
      else                         cmd = CMD_BAD_ON;
    end else begin
      if (midi == C_MIDI_STOP_ALL) cmd = CMD_STOP_ALL;
      else if (midi == C_MIDI_NONE) cmd = CMD_IGNORE;
      else                         cmd = CMD_NOTE_OFF;
    end
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/voice_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler_if
// Description : Command valid/ready channel into the voice scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface voice_scheduler_if;
  import voice_scheduler_pkg::*;

  logic                i_valid;
  logic [C_DATA_W-1:0] i_data;
  logic                o_ready;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);

endinterface
`default_nettype wire

// File: rtl/voice_dispatch_rr.sv
`default_nettype none
// ============================================================================
// Module      : voice_dispatch_rr
// Description : Round-robin slot dispatcher. On every clk_en strobe it
//               registers one slot of the table and advances the slot index.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_dispatch_rr #(
  parameter int unsigned NBANKS = 10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clk_en,
  input  logic [NBANKS-1:0][6:0]      i_slot_midi,
  input  logic [NBANKS-1:0][7:0]      i_slot_vel,
  output logic [6:0]                  o_midi,
  output logic [7:0]                  o_velocity,
  output logic [$clog2(NBANKS)-1:0]   o_slot,
  output logic                        o_valid
);
  localparam int unsigned IDX_W = $clog2(NBANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBANKS-1);

  logic [IDX_W-1:0] v_idx_q, v_idx_d;
  logic [6:0]       midi_q, midi_d;
  logic [7:0]       vel_q, vel_d;
  logic [IDX_W-1:0] slot_q, slot_d;
  logic             valid_q, valid_d;

  // Read the current slot and step the index only on a sample strobe.
  always_comb begin
    v_idx_d = v_idx_q;
    midi_d  = midi_q;
    vel_d   = vel_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    if (clk_en) begin
      midi_d  = i_slot_midi[v_idx_q];
      vel_d   = i_slot_vel[v_idx_q];
      slot_d  = v_idx_q;
      valid_d = (i_slot_midi[v_idx_q] != 7'h00);
      v_idx_d = (v_idx_q == LAST_IDX) ? '0 : v_idx_q + 1'b1;
    end
  end

  // Dispatcher registers; they read the table's current flops, so a same-edge
  // table write is seen on the following pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_idx_q <= '0;
      midi_q  <= '0;
      vel_q   <= '0;
      slot_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      v_idx_q <= v_idx_d;
      midi_q  <= midi_d;
      vel_q   <= vel_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  assign o_midi     = midi_q;
  assign o_velocity = vel_q;
  assign o_slot     = slot_q;
  assign o_valid    = valid_q;

endmodule
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler
// Description : Polyphony slot table with command FSM (IDLE/SCAN/COMMIT) and a
//               round-robin dispatcher feeding the phase-bank pipeline.
//               Build option VOICE_STEAL_EN: a note-on into a full table
//               replaces the oldest slot instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int unsigned NBANKS = 10,
  parameter int unsigned AGE_W  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clk_en,
  voice_scheduler_if.slave              cmd,
  output logic [6:0]                    o_midi,
  output logic [7:0]                    o_velocity,
  output logic [$clog2(NBANKS)-1:0]     o_slot,
  output logic                          o_valid,
  output logic [3:0]                    o_wave_en,
  output logic                          o_drop,
  output logic [$clog2(NBANKS+1)-1:0]   o_active_cnt
);
  localparam int unsigned IDX_W = $clog2(NBANKS);
  localparam int unsigned CNT_W = $clog2(NBANKS+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBANKS-1);
`ifdef VOICE_STEAL_EN
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
`endif

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          scan_idx_q, scan_idx_d;
  cmd_e                      cmd_q, cmd_d;
  logic [6:0]                cmd_midi_q, cmd_midi_d;
  logic [7:0]                cmd_vel_q, cmd_vel_d;
  logic                      free_found_q, free_found_d;
  logic [IDX_W-1:0]          free_idx_q, free_idx_d;
  logic                      match_found_q, match_found_d;
  logic [IDX_W-1:0]          match_idx_q, match_idx_d;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]          oldest_idx_q, oldest_idx_d;
  logic [AGE_W-1:0]          oldest_age_q, oldest_age_d;
  logic [NBANKS-1:0][AGE_W-1:0] age_q, age_d;
`endif
  logic [NBANKS-1:0][6:0]    midi_q, midi_d;
  logic [NBANKS-1:0][7:0]    vel_q, vel_d;
  wave_e                     wave_q, wave_d;
  logic [CNT_W-1:0]          active_cnt_q, active_cnt_d;
  logic                      drop_q, drop_d;
  logic                      alloc_en;
  logic [IDX_W-1:0]          alloc_idx;

  // Command FSM: accept and decode, scan the table, then apply one write.
  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    cmd_d         = cmd_q;
    cmd_midi_d    = cmd_midi_q;
    cmd_vel_d     = cmd_vel_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
`ifdef VOICE_STEAL_EN
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    age_d         = age_q;
`endif
    midi_d        = midi_q;
    vel_d         = vel_q;
    wave_d        = wave_q;
    active_cnt_d  = active_cnt_q;
    drop_d        = 1'b0;
    alloc_en      = 1'b0;
    alloc_idx     = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.i_valid) begin
          cmd_d         = decode_cmd(cmd.i_data);
          cmd_midi_d    = cmd.i_data[C_MIDI_MSB:C_MIDI_LSB];
          cmd_vel_d     = cmd.i_data[C_VEL_MSB:C_VEL_LSB];
          free_found_d  = 1'b0;
          match_found_d = 1'b0;
          scan_idx_d    = '0;
          // Only note commands need the table search.
          if (cmd_d == CMD_NOTE_ON || cmd_d == CMD_NOTE_OFF) state_d = ST_SCAN;
          else                                               state_d = ST_COMMIT;
        end
      end

      ST_SCAN: begin
        if (!free_found_q && midi_q[scan_idx_q] == C_MIDI_NONE) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (!match_found_q && midi_q[scan_idx_q] == cmd_midi_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
`ifdef VOICE_STEAL_EN
        // Strictly greater keeps the lowest index on an age tie.
        if (scan_idx_q == '0 || age_q[scan_idx_q] > oldest_age_q) begin
          oldest_idx_d = scan_idx_q;
          oldest_age_d = age_q[scan_idx_q];
        end
`endif
        // The scan always covers every slot so its length is fixed.
        if (scan_idx_q == LAST_IDX) state_d = ST_COMMIT;
        else                        scan_idx_d = scan_idx_q + 1'b1;
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        case (cmd_q)
          CMD_NOTE_ON: begin
            if (match_found_q) begin
              vel_d[match_idx_q] = cmd_vel_q;
            end else if (free_found_q) begin
              alloc_en     = 1'b1;
              alloc_idx    = free_idx_q;
              active_cnt_d = active_cnt_q + 1'b1;
            end else begin
`ifdef VOICE_STEAL_EN
              alloc_en  = 1'b1;
              alloc_idx = oldest_idx_q;
`else
              drop_d = 1'b1;
`endif
            end
          end
          CMD_NOTE_OFF: begin
            if (match_found_q) begin
              midi_d[match_idx_q] = C_MIDI_NONE;
              vel_d[match_idx_q]  = C_VEL_NONE;
`ifdef VOICE_STEAL_EN
              age_d[match_idx_q]  = '0;
`endif
              active_cnt_d = active_cnt_q - 1'b1;
            end
          end
          CMD_CHANGE_WAVE: wave_d = wave_e'(wave_q + 2'd1);
          CMD_STOP_ALL: begin
            midi_d       = '0;
            vel_d        = '0;
`ifdef VOICE_STEAL_EN
            age_d        = '0;
`endif
            active_cnt_d = '0;
          end
          CMD_BAD_ON: drop_d = 1'b1;
          default: ;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    // New allocation: every other occupied slot grows older, the new one is fresh.
    if (alloc_en) begin
`ifdef VOICE_STEAL_EN
      for (int i = 0; i < NBANKS; i++) begin
        if (IDX_W'(i) != alloc_idx && midi_q[i] != C_MIDI_NONE && age_q[i] != AGE_MAX)
          age_d[i] = age_q[i] + 1'b1;
      end
      age_d[alloc_idx] = '0;
`endif
      midi_d[alloc_idx] = cmd_midi_q;
      vel_d[alloc_idx]  = cmd_vel_q;
    end
  end

  // FSM, latched command, scan results and slot table registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      scan_idx_q    <= '0;
      cmd_q         <= CMD_IGNORE;
      cmd_midi_q    <= '0;
      cmd_vel_q     <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
`ifdef VOICE_STEAL_EN
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      age_q         <= '0;
`endif
      midi_q        <= '0;
      vel_q         <= '0;
      wave_q        <= WAVE_SINE;
      active_cnt_q  <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      cmd_q         <= cmd_d;
      cmd_midi_q    <= cmd_midi_d;
      cmd_vel_q     <= cmd_vel_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
`ifdef VOICE_STEAL_EN
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      age_q         <= age_d;
`endif
      midi_q        <= midi_d;
      vel_q         <= vel_d;
      wave_q        <= wave_d;
      active_cnt_q  <= active_cnt_d;
      drop_q        <= drop_d;
    end
  end

  assign cmd.o_ready    = (state_q == ST_IDLE);
  assign o_wave_en      = 4'b0001 << wave_q;
  assign o_drop         = drop_q;
  assign o_active_cnt   = active_cnt_q;

  voice_dispatch_rr #(
    .NBANKS (NBANKS)
  ) u_dispatch (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .i_slot_midi (midi_q),
    .i_slot_vel  (vel_q),
    .o_midi      (o_midi),
    .o_velocity  (o_velocity),
    .o_slot      (o_slot),
    .o_valid     (o_valid)
  );

endmodule
`default_nettype wire
